// File: rtl/aes_decrypt_iter.sv
`timescale 1ns/1ps
// aes_decrypt_iter
// Iterative AES inverse cipher (AES-128/192/256 chosen by NR). One inverse round is
// computed per clock on a single shared datapath. The full round-key schedule arrives
// together with each ciphertext block.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort back to idle
//   in_valid / in_ready   input handshake for ciphertext + round_keys
//   ciphertext            128-bit block to decrypt
//   round_keys            schedule, rk[i] = round_keys[(i+1)*128-1 : i*128]
//   out_valid / out_ready output handshake for plaintext
//   plaintext             128-bit decrypted block, held until the next completion
//   busy                  high while computing or holding a result
module aes_decrypt_iter #(
    parameter int unsigned  NR   = 10,
    localparam int unsigned RK_W = (NR + 1) * 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    ciphertext,
    input  logic [RK_W-1:0] round_keys,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    plaintext,
    output logic            busy
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
        $error("aes_decrypt_iter: NR must be 10, 12 or 14");
    end

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRound = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by the GF(2^8) inverse, computed as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] sq;
        logic [7:0] r;
        x  = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Byte n of the block sits at bits [127-8n -: 8]; byte 4c+r is row r of column c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                               gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                               gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                               gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                               gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [1:0]       fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    // rk[NR] is consumed on the accept edge, so only rk[0..NR-1] are held.
    logic [RK_W-129:0] rk_q, rk_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [127:0]     pt_q, pt_d;

    logic [127:0]     rk_sel;
    logic [127:0]     isb;
    logic [127:0]     ark;
    logic [127:0]     imc;

    // Shared round datapath; with rnd == 1 the selected key is rk[0] and ark is the result.
    always_comb begin
        rk_sel = '0;
        for (int i = 0; i < NR; i++) begin
            if (rnd_q == 4'(i + 1)) rk_sel = rk_q[i*128 +: 128];
        end
        isb = inv_sub_bytes(inv_shift_rows(state_q));
        ark = isb ^ rk_sel;
        imc = inv_mix_columns(ark);
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        pt_d    = pt_q;
        if (flush) begin
            fsm_d = StIdle;
            rnd_d = 4'd0;
        end else begin
            case (fsm_q)
                StIdle: begin
                    if (in_valid) begin
                        fsm_d   = StRound;
                        rk_d    = round_keys[RK_W-129:0];
                        state_d = ciphertext ^ round_keys[RK_W-1 -: 128];
                        rnd_d   = 4'(NR);
                    end
                end
                StRound: begin
                    if (rnd_q > 4'd1) begin
                        state_d = imc;
                        rnd_d   = rnd_q - 4'd1;
                    end else begin
                        pt_d  = ark;
                        rnd_d = 4'd0;
                        fsm_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) fsm_d = StIdle;
                end
                default: begin
                    fsm_d = StIdle;
                    rnd_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            pt_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
        end
    end

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q == StRound) || (fsm_q == StDone);
    assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
`timescale 1ns/1ps
// Self-checking bench for aes_decrypt_iter. Three instances (NR = 10, 12, 14) share the
// clock and reset. Expected plaintexts come from FIPS-197 constants or from a forward
// AES encryption model (key expansion + cipher) run on random plaintexts.
module tb_aes_decrypt_iter;

    typedef struct {
        int           k;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] FipsPt = 128'h00112233445566778899aabbccddeeff;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush_s     [3];
    logic           in_valid_s  [3];
    logic           out_ready_s [3];
    logic [127:0]   ct_s        [3];
    logic           in_ready_s  [3];
    logic           out_valid_s [3];
    logic           busy_s      [3];
    logic [127:0]   pt_s        [3];
    logic [1407:0]  rk10;
    logic [1663:0]  rk12;
    logic [1919:0]  rk14;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  [3] = '{0, 0, 0};
    int xfer_cnt [3] = '{0, 0, 0};

    logic [7:0] sbox [256];

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst_n && !flush_s[i] && in_valid_s[i] && in_ready_s[i])
                acc_cnt[i] <= acc_cnt[i] + 1;
            if (rst_n && !flush_s[i] && out_valid_s[i] && out_ready_s[i])
                xfer_cnt[i] <= xfer_cnt[i] + 1;
        end
    end

    aes_decrypt_iter #(.NR(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .flush(flush_s[0]), .in_valid(in_valid_s[0]),
        .in_ready(in_ready_s[0]), .ciphertext(ct_s[0]), .round_keys(rk10),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .plaintext(pt_s[0]),
        .busy(busy_s[0])
    );
    aes_decrypt_iter #(.NR(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .flush(flush_s[1]), .in_valid(in_valid_s[1]),
        .in_ready(in_ready_s[1]), .ciphertext(ct_s[1]), .round_keys(rk12),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .plaintext(pt_s[1]),
        .busy(busy_s[1])
    );
    aes_decrypt_iter #(.NR(14)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .flush(flush_s[2]), .in_valid(in_valid_s[2]),
        .in_ready(in_ready_s[2]), .ciphertext(ct_s[2]), .round_keys(rk14),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .plaintext(pt_s[2]),
        .busy(busy_s[2])
    );

    // ---------------- checking helpers ----------------
    task automatic chk_val(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    // ---------------- forward AES reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from the multiply-by-3 / divide-by-3 walk over the multiplicative group.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // Key is left-aligned in 256 bits; the schedule is packed with rk[i] at [i*128 +: 128].
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int            nk;
        nk = nr - 6;
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int i = 0; i <= nr; i++) r[i*128 +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return r;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] rks,
                                             input int nr);
        logic [127:0] s;
        s = pt ^ rks[127:0];
        for (int r = 1; r < nr; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rks[r*128 +: 128];
        return shift_rows(sub_bytes(s)) ^ rks[nr*128 +: 128];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_rk(input int k, input logic [1919:0] v);
        case (k)
            0:       rk10 = v[1407:0];
            1:       rk12 = v[1663:0];
            default: rk14 = v;
        endcase
    endtask

    function automatic logic [1919:0] rand_bits();
        logic [1919:0] v;
        for (int j = 0; j < 60; j++) v[32*j +: 32] = $urandom();
        return v;
    endfunction

    // Accept one block with out_ready high and check latency, pulse and return to idle.
    task automatic run_vec(input int k, input logic [255:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input string nm);
        int nr, n;
        nr = 10 + 2 * k;
        out_ready_s[k] = 1'b1;
        chk_bit({nm, " in_ready before accept"}, in_ready_s[k], 1'b1);
        set_rk(k, expand(key, nr));
        ct_s[k] = ct;
        in_valid_s[k] = 1'b1;
        @(negedge clk);
        in_valid_s[k] = 1'b0;
        chk_bit({nm, " busy after accept"}, busy_s[k], 1'b1);
        chk_bit({nm, " in_ready after accept"}, in_ready_s[k], 1'b0);
        n = 0;
        while (!out_valid_s[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_s[k]) fail_timeout({nm, " out_valid"});
        chk_int({nm, " latency"}, n, nr);
        chk_val({nm, " plaintext"}, pt_s[k], pt);
        @(negedge clk);
        chk_bit({nm, " out_valid one-cycle pulse"}, out_valid_s[k], 1'b0);
        chk_bit({nm, " in_ready after handshake"}, in_ready_s[k], 1'b1);
        chk_bit({nm, " busy after handshake"}, busy_s[k], 1'b0);
        chk_val({nm, " plaintext held after handshake"}, pt_s[k], pt);
    endtask

    task automatic rand_run(input int k, input int nblk);
        int           nr, n;
        bit           done;
        logic [255:0] key;
        logic [127:0] pt;
        logic [1919:0] rks;
        nr = 10 + 2 * k;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom();
            for (int j = 0; j < 4; j++) pt[32*j +: 32] = $urandom();
            rks = expand(key, nr);
            n = 0;
            while (!in_ready_s[k] && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready_s[k]) fail_timeout($sformatf("rand nr%0d in_ready", nr));
            set_rk(k, rks);
            ct_s[k] = encrypt(pt, rks, nr);
            in_valid_s[k] = 1'b1;
            @(negedge clk);
            in_valid_s[k] = 1'b0;
            done = 1'b0;
            n = 0;
            while (!done && n < 80) begin
                out_ready_s[k] = ($urandom_range(0, 3) != 0);
                if (out_valid_s[k] && out_ready_s[k]) begin
                    chk_val($sformatf("rand nr%0d block %0d", nr, b), pt_s[k], pt);
                    done = 1'b1;
                end
                @(negedge clk);
                n++;
            end
            if (!done) fail_timeout($sformatf("rand nr%0d block %0d", nr, b));
        end
        out_ready_s[k] = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    vec_t          vecs [4];
    logic [127:0]  bk_ct [3];
    logic [127:0]  bk_pt [3];
    logic [1919:0] bk_rk [3];
    int            acc_at [3];
    int            n, a0, x0, seen;
    logic [255:0]  kb;

    initial begin
        for (int i = 0; i < 3; i++) begin
            flush_s[i] = 1'b0;
            in_valid_s[i] = 1'b0;
            out_ready_s[i] = 1'b1;
            ct_s[i] = '0;
        end
        rk10 = '0;
        rk12 = '0;
        rk14 = '0;
        build_sbox();

        vecs[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, FipsPt};
        vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, FipsPt};
        vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, FipsPt};
        vecs[3] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};

        // Reset values while rst_n is low.
        #2;
        for (int k = 0; k < 3; k++) begin
            chk_bit($sformatf("reset in_ready %0d", k), in_ready_s[k], 1'b1);
            chk_bit($sformatf("reset out_valid %0d", k), out_valid_s[k], 1'b0);
            chk_bit($sformatf("reset busy %0d", k), busy_s[k], 1'b0);
            chk_val($sformatf("reset plaintext %0d", k), pt_s[k], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i].k, vecs[i].key, vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));

        // Backpressure on NR=10: inputs scrambled and in_valid held high while busy.
        kb = vecs[3].key;
        out_ready_s[0] = 1'b0;
        set_rk(0, expand(kb, 10));
        ct_s[0] = vecs[3].ct;
        in_valid_s[0] = 1'b1;
        a0 = acc_cnt[0];
        x0 = xfer_cnt[0];
        @(negedge clk);
        n = 0;
        while (!out_valid_s[0] && n < 60) begin
            ct_s[0] = rand_bits()[127:0];
            set_rk(0, rand_bits());
            @(negedge clk);
            n++;
        end
        if (!out_valid_s[0]) fail_timeout("bp out_valid");
        chk_int("bp latency", n, 10);
        for (int i = 0; i < 7; i++) begin
            chk_val($sformatf("bp plaintext stall %0d", i), pt_s[0], vecs[3].pt);
            chk_bit($sformatf("bp out_valid stall %0d", i), out_valid_s[0], 1'b1);
            chk_bit($sformatf("bp in_ready stall %0d", i), in_ready_s[0], 1'b0);
            ct_s[0] = rand_bits()[127:0];
            @(negedge clk);
        end
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        chk_bit("bp out_valid after release", out_valid_s[0], 1'b0);
        chk_int("bp transfers", xfer_cnt[0] - x0, 1);
        chk_int("bp accepts", acc_cnt[0] - a0, 1);
        chk_val("bp plaintext kept", pt_s[0], vecs[3].pt);

        // Back-to-back on NR=12 with in_valid held high. Each block takes the accept cycle
        // plus NR round cycles, one DONE cycle and one IDLE cycle before the next accept.
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 8; j++) kb[32*j +: 32] = $urandom();
            bk_rk[b] = expand(kb, 12);
            bk_pt[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
            bk_ct[b] = encrypt(bk_pt[b], bk_rk[b], 12);
        end
        out_ready_s[1] = 1'b1;
        in_valid_s[1] = 1'b1;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    int t;
                    t = 0;
                    while (!in_ready_s[1] && t < 100) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!in_ready_s[1]) fail_timeout($sformatf("b2b accept %0d", b));
                    set_rk(1, bk_rk[b]);
                    ct_s[1] = bk_ct[b];
                    acc_at[b] = cyc;
                    @(negedge clk);
                end
                in_valid_s[1] = 1'b0;
            end
            begin
                for (int b = 0; b < 3; b++) begin
                    int t;
                    t = 0;
                    while (!out_valid_s[1] && t < 100) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!out_valid_s[1]) fail_timeout($sformatf("b2b result %0d", b));
                    chk_val($sformatf("b2b result %0d", b), pt_s[1], bk_pt[b]);
                    @(negedge clk);
                end
            end
        join
        chk_int("b2b spacing 0-1", acc_at[1] - acc_at[0], 14);
        chk_int("b2b spacing 1-2", acc_at[2] - acc_at[1], 14);

        // Flush during round 5 of NR=10: plaintext keeps the backpressure result.
        set_rk(0, expand(vecs[0].key, 10));
        ct_s[0] = vecs[0].ct;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        flush_s[0] = 1'b1;
        @(negedge clk);
        flush_s[0] = 1'b0;
        chk_bit("flush in_ready", in_ready_s[0], 1'b1);
        chk_bit("flush busy", busy_s[0], 1'b0);
        chk_bit("flush out_valid", out_valid_s[0], 1'b0);
        chk_val("flush plaintext unchanged", pt_s[0], vecs[3].pt);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_s[0] || busy_s[0]) seen++;
        end
        chk_int("flush stays idle", seen, 0);

        // Flush together with in_valid in IDLE: nothing accepted.
        a0 = acc_cnt[0];
        flush_s[0] = 1'b1;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        flush_s[0] = 1'b0;
        in_valid_s[0] = 1'b0;
        chk_bit("flush+in_valid busy", busy_s[0], 1'b0);
        chk_bit("flush+in_valid in_ready", in_ready_s[0], 1'b1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_s[0] || busy_s[0]) seen++;
        end
        chk_int("flush+in_valid no activity", seen, 0);
        chk_int("flush+in_valid accepts", acc_cnt[0] - a0, 0);

        // Flush together with the output handshake in DONE on NR=14.
        out_ready_s[2] = 1'b1;
        set_rk(2, expand(vecs[2].key, 14));
        ct_s[2] = vecs[2].ct;
        in_valid_s[2] = 1'b1;
        @(negedge clk);
        in_valid_s[2] = 1'b0;
        n = 0;
        while (!out_valid_s[2] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_s[2]) fail_timeout("flush in done out_valid");
        flush_s[2] = 1'b1;
        @(negedge clk);
        flush_s[2] = 1'b0;
        chk_bit("flush in done out_valid", out_valid_s[2], 1'b0);
        chk_bit("flush in done in_ready", in_ready_s[2], 1'b1);
        chk_val("flush in done plaintext", pt_s[2], FipsPt);

        // Asynchronous reset in the middle of a block.
        set_rk(0, expand(vecs[0].key, 10));
        ct_s[0] = vecs[0].ct;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk_bit("pre-reset busy", busy_s[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_bit($sformatf("async reset in_ready %0d", k), in_ready_s[k], 1'b1);
            chk_bit($sformatf("async reset out_valid %0d", k), out_valid_s[k], 1'b0);
            chk_bit($sformatf("async reset busy %0d", k), busy_s[k], 1'b0);
            chk_val($sformatf("async reset plaintext %0d", k), pt_s[k], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, vecs[0].key, vecs[0].ct, vecs[0].pt, "post-reset");

        // Random blocks against the forward model, all three widths in parallel.
        fork
            rand_run(0, 1000);
            rand_run(1, 1000);
            rand_run(2, 1000);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
